// File: rtl/spi_wb_burst_bridge.sv
// spi_wb_burst_bridge
//   SPI slave (mode 1: CPOL=0, CPHA=1) to Wishbone master bridge.
//   Frame: [CMD][ADDR x ADDR_BYTES][DATA word x N], MSB first, N unbounded
//   while spi_cs_n stays low. Commands: 0x00 single read, 0x01 single write,
//   0x02 burst read, 0x03 burst write; anything else is ignored until CS high.
//   Burst commands auto-increment the address after every data word; reads
//   are prefetched one word ahead.
// Ports
//   clk, rst_n              system clock, asynchronous active-low reset
//   spi_sclk/mosi/cs_n      SPI inputs (asynchronous to clk)
//   spi_miso                SPI data out (1 when not returning read data)
//   wb_adr_o/dat_o/we_o     Wishbone master address, write data, write enable
//   wb_cyc_o/stb_o          Wishbone cycle and strobe (always asserted together)
//   wb_dat_i/ack_i          Wishbone read data and acknowledge
//   busy_o                  a Wishbone cycle is outstanding
//   err_o                   sticky overrun/underrun/timeout flag, cleared on CS fall
module spi_wb_burst_bridge #(
  parameter int ADDR_BYTES     = 2,
  parameter int DATA_BYTES     = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    spi_sclk,
  input  logic                    spi_mosi,
  output logic                    spi_miso,
  input  logic                    spi_cs_n,
  output logic [8*ADDR_BYTES-1:0] wb_adr_o,
  output logic [8*DATA_BYTES-1:0] wb_dat_o,
  input  logic [8*DATA_BYTES-1:0] wb_dat_i,
  output logic                    wb_we_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  input  logic                    wb_ack_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  localparam int SW = (AW > DW) ? AW : DW;
  localparam int BW = $clog2(SW + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {RX_CMD, RX_ADDR, RX_DATA, RX_IGN} rx_state_t;
  typedef enum logic {WB_IDLE, WB_WAIT} wb_state_t;

  rx_state_t       rx_state;
  wb_state_t       wb_state;

  logic [2:0]      sclk_sync;
  logic [2:0]      cs_sync;
  logic [1:0]      mosi_sync;
  logic [BW-1:0]   bit_cnt;
  logic [SW-1:0]   rx_sh;
  logic [1:0]      cmd;          // [1]=burst, [0]=write
  logic [AW-1:0]   addr;
  logic [DW-1:0]   tx_sh;
  logic [DW-1:0]   tx_buf;
  logic            buf_valid;
  logic            rd_pend;
  logic            req;
  logic            req_we;
  logic [AW-1:0]   req_adr;
  logic [DW-1:0]   req_dat;
  logic            err_rx;
  logic            rd_done;
  logic            drop;
  logic [TW-1:0]   tcnt;

  // Edges are taken between sync stages 2 and 3 so each is seen exactly once.
  logic sclk_rise, sclk_fall, cs_active, cs_fall, mosi_bit, wb_free, can_rd;
  logic [AW-1:0] addr_in, pf_adr;
  logic [DW-1:0] word_in;

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cs_active = ~cs_sync[1];
  assign cs_fall   = cs_sync[2] & ~cs_sync[1];
  assign mosi_bit  = mosi_sync[1];
  assign addr_in   = {rx_sh[AW-2:0], mosi_bit};
  assign word_in   = {rx_sh[DW-2:0], mosi_bit};
  assign pf_adr    = cmd[1] ? addr + AW'(1) : addr;
  // A request pulse in flight counts as busy: only one cycle may be outstanding.
  assign wb_free   = (wb_state == WB_IDLE) && !req;
  assign can_rd    = wb_free && !rd_pend;
  assign busy_o    = (wb_state == WB_WAIT);

  // SPI receive / transmit side
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      rx_state  <= RX_CMD;
      bit_cnt   <= '0;
      rx_sh     <= '0;
      cmd       <= '0;
      addr      <= '0;
      tx_sh     <= '1;
      buf_valid <= 1'b0;
      rd_pend   <= 1'b0;
      req       <= 1'b0;
      req_we    <= 1'b0;
      req_adr   <= '0;
      req_dat   <= '0;
      err_rx    <= 1'b0;
      spi_miso  <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi_sclk};
      cs_sync   <= {cs_sync[1:0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      req       <= 1'b0;
      err_rx    <= 1'b0;
      if (!cs_active) begin
        rx_state  <= RX_CMD;
        bit_cnt   <= '0;
        rd_pend   <= 1'b0;
        buf_valid <= 1'b0;
      end else begin
        if (rd_done)
          buf_valid <= 1'b1;
        // A read that could not start because the bus was busy goes out now.
        if (rd_pend && wb_free) begin
          req     <= 1'b1;
          req_we  <= 1'b0;
          req_adr <= addr;
          rd_pend <= 1'b0;
        end
        if (sclk_fall) begin
          rx_sh   <= {rx_sh[SW-2:0], mosi_bit};
          bit_cnt <= bit_cnt + BW'(1);
          case (rx_state)
            RX_CMD: begin
              if (bit_cnt == BW'(7)) begin
                bit_cnt <= '0;
                if (rx_sh[6:1] == 6'd0) begin
                  cmd      <= {rx_sh[0], mosi_bit};
                  rx_state <= RX_ADDR;
                end else begin
                  rx_state <= RX_IGN;
                end
              end
            end
            RX_ADDR: begin
              if (bit_cnt == BW'(AW - 1)) begin
                bit_cnt  <= '0;
                rx_state <= RX_DATA;
                addr     <= addr_in;
                if (!cmd[0]) begin
                  if (can_rd) begin
                    req     <= 1'b1;
                    req_we  <= 1'b0;
                    req_adr <= addr_in;
                  end else begin
                    rd_pend <= 1'b1;
                  end
                end
              end
            end
            RX_DATA: begin
              // First falling edge of a read word: move the buffer into the
              // shifter and prefetch the following word.
              if (bit_cnt == '0 && !cmd[0]) begin
                tx_sh     <= buf_valid ? tx_buf : '1;
                buf_valid <= 1'b0;
                if (!buf_valid)
                  err_rx <= 1'b1;
                addr <= pf_adr;
                if (can_rd) begin
                  req     <= 1'b1;
                  req_we  <= 1'b0;
                  req_adr <= pf_adr;
                end else begin
                  rd_pend <= 1'b1;
                end
              end
              if (bit_cnt == BW'(DW - 1)) begin
                bit_cnt <= '0;
                if (cmd[0]) begin
                  if (wb_free) begin
                    req     <= 1'b1;
                    req_we  <= 1'b1;
                    req_adr <= addr;
                    req_dat <= word_in;
                  end else begin
                    err_rx <= 1'b1;
                  end
                  if (cmd[1])
                    addr <= addr + AW'(1);
                end
              end
            end
            default: ;
          endcase
        end else if (sclk_rise && rx_state == RX_DATA && !cmd[0] && bit_cnt != '0) begin
          tx_sh <= {tx_sh[DW-2:0], 1'b1};
        end
      end
      // Before a read word's first falling edge the MSB comes straight from
      // the buffer; afterwards from the shifter.
      if (cs_active && rx_state == RX_DATA && !cmd[0])
        spi_miso <= (bit_cnt == '0) ? (buf_valid ? tx_buf[DW-1] : 1'b1) : tx_sh[DW-1];
      else
        spi_miso <= 1'b1;
    end
  end

  // Wishbone master side
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_state <= WB_IDLE;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      tcnt     <= '0;
      tx_buf   <= '0;
      rd_done  <= 1'b0;
      drop     <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      if (cs_fall)
        err_o <= 1'b0;
      if (err_rx)
        err_o <= 1'b1;
      case (wb_state)
        WB_IDLE: begin
          if (req) begin
            wb_adr_o <= req_adr;
            wb_we_o  <= req_we;
            if (req_we)
              wb_dat_o <= req_dat;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            tcnt     <= '0;
            drop     <= !cs_active;
            wb_state <= WB_WAIT;
          end
        end
        default: begin
          // The cycle always runs to ack or timeout; CS high only marks its
          // read data as stale.
          if (!cs_active)
            drop <= 1'b1;
          if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_state <= WB_IDLE;
            if (!wb_we_o && !drop && cs_active) begin
              tx_buf  <= wb_dat_i;
              rd_done <= 1'b1;
            end
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_state <= WB_IDLE;
            err_o    <= 1'b1;
            if (!wb_we_o && !drop && cs_active) begin
              tx_buf  <= '1;
              rd_done <= 1'b1;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_wb_burst_bridge.sv
module tb_spi_wb_burst_bridge;

  localparam int H = 8;   // SCLK half period in clk cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0, mosi = 1'b0;
  logic cs_a = 1'b1, cs_b = 1'b1, cs_c = 1'b1;
  logic miso_a, miso_b, miso_c;

  logic [15:0] adr_a, adr_b, adr_c;
  logic [7:0]  dat_o_a, dat_o_c;
  logic [15:0] dat_o_b;
  logic [7:0]  dat_i_a = 8'h00, dat_i_c = 8'h00;
  logic [15:0] dat_i_b = 16'hBEEF;
  logic we_a, we_b, we_c, cyc_a, cyc_b, cyc_c, stb_a, stb_b, stb_c;
  logic ack_a = 1'b0, ack_b = 1'b0, ack_c = 1'b0;
  logic busy_a, busy_b, busy_c, err_a, err_b, err_c;

  always #5 clk = ~clk;

  spi_wb_burst_bridge #(.ADDR_BYTES(2), .DATA_BYTES(1), .TIMEOUT_CYCLES(255)) dut_a (
    .clk(clk), .rst_n(rst_n), .spi_sclk(sclk), .spi_mosi(mosi), .spi_miso(miso_a),
    .spi_cs_n(cs_a), .wb_adr_o(adr_a), .wb_dat_o(dat_o_a), .wb_dat_i(dat_i_a),
    .wb_we_o(we_a), .wb_cyc_o(cyc_a), .wb_stb_o(stb_a), .wb_ack_i(ack_a),
    .busy_o(busy_a), .err_o(err_a));

  spi_wb_burst_bridge #(.ADDR_BYTES(2), .DATA_BYTES(2), .TIMEOUT_CYCLES(255)) dut_b (
    .clk(clk), .rst_n(rst_n), .spi_sclk(sclk), .spi_mosi(mosi), .spi_miso(miso_b),
    .spi_cs_n(cs_b), .wb_adr_o(adr_b), .wb_dat_o(dat_o_b), .wb_dat_i(dat_i_b),
    .wb_we_o(we_b), .wb_cyc_o(cyc_b), .wb_stb_o(stb_b), .wb_ack_i(ack_b),
    .busy_o(busy_b), .err_o(err_b));

  spi_wb_burst_bridge #(.ADDR_BYTES(2), .DATA_BYTES(1), .TIMEOUT_CYCLES(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .spi_sclk(sclk), .spi_mosi(mosi), .spi_miso(miso_c),
    .spi_cs_n(cs_c), .wb_adr_o(adr_c), .wb_dat_o(dat_o_c), .wb_dat_i(dat_i_c),
    .wb_we_o(we_c), .wb_cyc_o(cyc_c), .wb_stb_o(stb_c), .wb_ack_i(ack_c),
    .busy_o(busy_c), .err_o(err_c));

  // Bus slaves and cycle logs, all updated on the falling clk edge.
  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat;
  } rec_t;

  rec_t log_a[$], log_b[$], log_c[$];
  int   len_c[$];
  int   run_c = 0;
  logic cyc_a_q = 1'b0, cyc_b_q = 1'b0, cyc_c_q = 1'b0;
  logic [7:0] mem [256];

  always @(negedge clk) begin
    if (cyc_a && !cyc_a_q) log_a.push_back('{we_a, adr_a, {8'h00, dat_o_a}});
    if (cyc_b && !cyc_b_q) log_b.push_back('{we_b, adr_b, dat_o_b});
    if (cyc_c && !cyc_c_q) log_c.push_back('{we_c, adr_c, {8'h00, dat_o_c}});
    cyc_a_q = cyc_a;
    cyc_b_q = cyc_b;
    cyc_c_q = cyc_c;
    if (cyc_c) run_c++;
    else if (run_c != 0) begin
      len_c.push_back(run_c);
      run_c = 0;
    end
    if (cyc_a && stb_a && !ack_a && we_a) mem[adr_a[7:0]] = dat_o_a;
    dat_i_a = mem[adr_a[7:0]];
    ack_a = cyc_a && stb_a && !ack_a;
    ack_b = cyc_b && stb_b && !ack_b;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic cur_miso(input int sel);
    case (sel)
      0: return miso_a;
      1: return miso_b;
      default: return miso_c;
    endcase
  endfunction

  task automatic set_cs(input int sel, input logic v);
    case (sel)
      0: cs_a = v;
      1: cs_b = v;
      default: cs_c = v;
    endcase
  endtask

  // Mode 1: drive MOSI on the rising SCLK edge, sample MISO at the falling edge.
  task automatic spi_byte(input int sel, input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      sclk = 1'b1;
      mosi = tx[i];
      tick(H);
      rx[i] = cur_miso(sel);
      sclk = 1'b0;
      tick(H);
    end
  endtask

  logic [7:0] ftx [8];
  logic [7:0] frx [8];

  task automatic frame(input int sel, input int n);
    set_cs(sel, 1'b0);
    tick(H);
    for (int k = 0; k < n; k++) spi_byte(sel, ftx[k], frx[k]);
    tick(H);
    set_cs(sel, 1'b1);
    tick(40);
  endtask

  typedef struct {
    int              n;
    logic [0:5][7:0] tx;
    logic [0:5][7:0] rx;
    int              ncyc;
    logic [0:3]      we;
    logic [0:3][15:0] adr;
    logic [0:3][7:0] dat;
  } vec_t;

  vec_t vt [6];

  initial begin
    logic [7:0] junk;

    vt[0] = '{n: 4, tx: {8'h01, 8'h12, 8'h34, 8'hA5, 16'h0000},
              rx: {8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'h0000},
              ncyc: 1, we: 4'b1000, adr: {16'h1234, 48'h0}, dat: {8'hA5, 24'h0}};
    vt[1] = '{n: 6, tx: {8'h03, 8'h00, 8'h10, 8'h11, 8'h22, 8'h33},
              rx: {48'hFFFF_FFFF_FFFF},
              ncyc: 3, we: 4'b1110, adr: {16'h0010, 16'h0011, 16'h0012, 16'h0},
              dat: {8'h11, 8'h22, 8'h33, 8'h00}};
    vt[2] = '{n: 6, tx: {8'h02, 8'h00, 8'h20, 8'hFF, 8'hFF, 8'hFF},
              rx: {8'hFF, 8'hFF, 8'hFF, 8'hAA, 8'hBB, 8'hCC},
              ncyc: 4, we: 4'b0000, adr: {16'h0020, 16'h0021, 16'h0022, 16'h0023}, dat: 32'h0};
    vt[3] = '{n: 5, tx: {8'h00, 8'h00, 8'h21, 8'hFF, 8'hFF, 8'h00},
              rx: {8'hFF, 8'hFF, 8'hFF, 8'hBB, 8'hBB, 8'h00},
              ncyc: 3, we: 4'b0000, adr: {16'h0021, 16'h0021, 16'h0021, 16'h0}, dat: 32'h0};
    vt[4] = '{n: 5, tx: {8'h03, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00},
              rx: {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00},
              ncyc: 2, we: 4'b1100, adr: {16'hFFFF, 16'h0000, 32'h0}, dat: {8'h01, 8'h02, 16'h0}};
    vt[5] = '{n: 4, tx: {8'h7E, 8'h00, 8'h00, 8'h55, 16'h0000},
              rx: {8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'h0000},
              ncyc: 0, we: 4'b0000, adr: 64'h0, dat: 32'h0};

    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h20] = 8'hAA;
    mem[8'h21] = 8'hBB;
    mem[8'h22] = 8'hCC;

    // Reset state
    tick(3);
    chk("rst miso", {31'd0, miso_a}, 32'd1);
    chk("rst cyc/stb/we", {29'd0, cyc_a, stb_a, we_a}, 32'd0);
    chk("rst adr", {16'd0, adr_a}, 32'd0);
    chk("rst dat", {24'd0, dat_o_a}, 32'd0);
    chk("rst busy/err", {30'd0, busy_a, err_a}, 32'd0);
    rst_n = 1'b1;
    tick(5);

    // Table-driven frames on the 8-bit bridge
    for (int v = 0; v < 6; v++) begin
      log_a.delete();
      for (int k = 0; k < 6; k++) ftx[k] = vt[v].tx[k];
      frame(0, vt[v].n);
      for (int k = 0; k < vt[v].n; k++)
        chk($sformatf("v%0d miso byte%0d", v, k), {24'd0, frx[k]}, {24'd0, vt[v].rx[k]});
      chk($sformatf("v%0d cycles", v), log_a.size(), vt[v].ncyc);
      for (int c = 0; c < vt[v].ncyc; c++) begin
        if (c < log_a.size()) begin
          chk($sformatf("v%0d cyc%0d adr", v, c), {16'd0, log_a[c].adr}, {16'd0, vt[v].adr[c]});
          chk($sformatf("v%0d cyc%0d we", v, c), {31'd0, log_a[c].we}, {31'd0, vt[v].we[c]});
          if (vt[v].we[c])
            chk($sformatf("v%0d cyc%0d dat", v, c), {16'd0, log_a[c].dat}, {24'd0, vt[v].dat[c]});
        end
      end
      chk($sformatf("v%0d err", v), {31'd0, err_a}, 32'd0);
    end
    chk("mem[0xFF] after wrap write", {24'd0, mem[8'hFF]}, 32'h01);
    chk("mem[0x00] after wrap write", {24'd0, mem[8'h00]}, 32'h02);

    // 16-bit data word, address 0xFFFF
    log_b.delete();
    ftx[0] = 8'h00; ftx[1] = 8'hFF; ftx[2] = 8'hFF; ftx[3] = 8'hFF; ftx[4] = 8'hFF;
    frame(1, 5);
    chk("w16 miso hi", {24'd0, frx[3]}, 32'hBE);
    chk("w16 miso lo", {24'd0, frx[4]}, 32'hEF);
    chk("w16 cycles", log_b.size(), 2);
    if (log_b.size() > 0) chk("w16 adr", {16'd0, log_b[0].adr}, 32'hFFFF);
    if (log_b.size() > 1) chk("w16 prefetch adr", {16'd0, log_b[1].adr}, 32'hFFFF);
    chk("w16 err", {31'd0, err_b}, 32'd0);

    // Timeout: slave never acknowledges
    log_c.delete();
    len_c.delete();
    chk("to err before", {31'd0, err_c}, 32'd0);
    ftx[0] = 8'h00; ftx[1] = 8'h00; ftx[2] = 8'h05; ftx[3] = 8'hFF;
    frame(2, 4);
    chk("to miso", {24'd0, frx[3]}, 32'hFF);
    chk("to cycles", len_c.size(), 2);
    if (len_c.size() > 0) chk("to cyc length", len_c[0], 8);
    if (log_c.size() > 0) chk("to adr", {16'd0, log_c[0].adr}, 32'h0005);
    chk("to err sticky", {31'd0, err_c}, 32'd1);
    cs_c = 1'b0;
    tick(6);
    chk("to err cleared by cs fall", {31'd0, err_c}, 32'd0);
    cs_c = 1'b1;
    tick(10);

    // Reset in the middle of a burst write
    log_a.delete();
    cs_a = 1'b0;
    tick(H);
    spi_byte(0, 8'h03, junk);
    spi_byte(0, 8'h00, junk);
    spi_byte(0, 8'h40, junk);
    spi_byte(0, 8'h11, junk);
    sclk = 1'b1;
    mosi = 1'b0;
    tick(3);
    chk("mid adr before reset", {16'd0, adr_a}, 32'h0040);
    rst_n = 1'b0;
    tick(1);
    chk("mid rst miso", {31'd0, miso_a}, 32'd1);
    chk("mid rst cyc/stb/we", {29'd0, cyc_a, stb_a, we_a}, 32'd0);
    chk("mid rst adr", {16'd0, adr_a}, 32'd0);
    chk("mid rst dat", {24'd0, dat_o_a}, 32'd0);
    chk("mid rst busy/err", {30'd0, busy_a, err_a}, 32'd0);
    sclk = 1'b0;
    cs_a = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("mid cycles before reset", log_a.size(), 1);

    log_a.delete();
    ftx[0] = 8'h01; ftx[1] = 8'h00;
    frame(0, 2);
    chk("partial frame cycles", log_a.size(), 0);
    ftx[0] = 8'h01; ftx[1] = 8'h00; ftx[2] = 8'h01; ftx[3] = 8'h5A;
    frame(0, 4);
    chk("post-reset cycles", log_a.size(), 1);
    if (log_a.size() > 0) begin
      chk("post-reset adr", {16'd0, log_a[0].adr}, 32'h0001);
      chk("post-reset we", {31'd0, log_a[0].we}, 32'd1);
      chk("post-reset dat", {16'd0, log_a[0].dat}, 32'h5A);
    end
    chk("post-reset mem", {24'd0, mem[8'h01]}, 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
